// File: rtl/mur_briques.sv
// Brick wall for a breakout game: alive bitmap, per-brick pixel zones, registered
// colour output, and a hit/refill FSM that only touches the bitmap during vertical blanking.

module brique_zone #(
  parameter int HLO = 0,
  parameter int HHI = 1,
  parameter int VLO = 0,
  parameter int VHI = 1
) (
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  output logic        dedans
);
  assign dedans = (hpos >= 11'(HLO)) && (hpos < 11'(HHI)) &&
                  (vpos >= 11'(VLO)) && (vpos < 11'(VHI));
endmodule

module mur_briques #(
  parameter int NB_COL            = 3,
  parameter int NB_ROW            = 6,
  parameter int LARGEUR_BRIQUE    = 210,
  parameter int HAUTEUR_BRIQUE    = 80,
  parameter int INTERVALLE_BRIQUE = 1,
  parameter int H_DEBUT           = 112,
  parameter int V_BAS             = 492,
  parameter int COULEUR_BRIQUE    = 18,
  parameter int BLANC             = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        hit_req,
  input  logic [1:0]  hit_col,
  input  logic [2:0]  hit_row,
  input  logic        new_level,
  output logic        hit_ack,
  output logic        hit_valid,
  output logic [4:0]  couleur,
  output logic [7:0]  score,
  output logic        wall_empty
);
  localparam int NB = NB_COL * NB_ROW;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ATTENTE  = 2'd1;
  localparam logic [1:0] APPLIQUE = 2'd2;
  localparam logic [1:0] RECHARGE = 2'd3;

  logic [1:0]    state;
  logic [NB-1:0] alive, dedans, sel;
  logic [1:0]    cap_col;
  logic [2:0]    cap_row;
  logic          valid_q;
  logic          blank;

  assign blank = (vpos < 11'(V_BAS - 480)) || (vpos >= 11'(V_BAS));

  // One zone decoder and one coordinate match per brick; out-of-range captures match nothing.
  for (genvar c = 0; c < NB_COL; c++) begin : g_col
    for (genvar r = 0; r < NB_ROW; r++) begin : g_row
      brique_zone #(
        .HLO(H_DEBUT + LARGEUR_BRIQUE * c + INTERVALLE_BRIQUE),
        .HHI(H_DEBUT + LARGEUR_BRIQUE * (c + 1) - INTERVALLE_BRIQUE),
        .VLO(V_BAS - (HAUTEUR_BRIQUE * (r + 1) - INTERVALLE_BRIQUE)),
        .VHI(V_BAS - (HAUTEUR_BRIQUE * r + INTERVALLE_BRIQUE))
      ) u_zone (
        .hpos  (hpos),
        .vpos  (vpos),
        .dedans(dedans[c*NB_ROW+r])
      );
      assign sel[c*NB_ROW+r] = (cap_col == 2'(c)) && (cap_row == 3'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) couleur <= '0;
    else        couleur <= (|(dedans & alive)) ? 5'(COULEUR_BRIQUE) : 5'(BLANC);
  end

  // The hit decision and bit clear are latched on the blanking edge that leaves ATTENTE,
  // so the bitmap never moves once active video resumes; APPLIQUE then reports it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      alive   <= '1;
      cap_col <= '0;
      cap_row <= '0;
      valid_q <= 1'b0;
      score   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (new_level) state <= RECHARGE;
          else if (hit_req) begin
            cap_col <= hit_col;
            cap_row <= hit_row;
            state   <= ATTENTE;
          end
        end
        ATTENTE: begin
          if (blank) begin
            valid_q <= |(sel & alive);
            alive   <= alive & ~sel;
            state   <= APPLIQUE;
          end
        end
        APPLIQUE: begin
          if (valid_q && (score != 8'hFF)) score <= score + 8'd1;
          state <= IDLE;
        end
        RECHARGE: begin
          if (blank) begin
            alive <= '1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wall_empty <= 1'b0;
    else        wall_empty <= (alive == '0);
  end

  assign hit_ack   = (state == APPLIQUE);
  assign hit_valid = hit_ack & valid_q;

endmodule

// File: tb/tb_mur_briques.sv
// Self-checking bench for mur_briques: pixel vector table, directed hit/refill/reset
// sequences and randomized hits against a bitmap/score model.

module tb_mur_briques;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hpos = '0, vpos = '0;
  logic        hit_req = 1'b0, new_level = 1'b0;
  logic [1:0]  hit_col = '0;
  logic [2:0]  hit_row = '0;
  logic        hit_ack, hit_valid, wall_empty;
  logic [4:0]  couleur;
  logic [7:0]  score;

  int checks = 0, errors = 0, ack_cnt = 0;
  bit alive [3][6];
  int m_score = 0;

  mur_briques dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .hit_req(hit_req), .hit_col(hit_col), .hit_row(hit_row), .new_level(new_level),
    .hit_ack(hit_ack), .hit_valid(hit_valid), .couleur(couleur), .score(score),
    .wall_empty(wall_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hit_ack) ack_cnt++;

  always @(negedge clk) if (hit_valid && !hit_ack) begin
    checks++; errors++;
    $display("FAIL valid_without_ack: hit_valid=1 hit_ack=0 at %0t", $time);
  end

  typedef struct { int h; int v; int c; } pix_t;
  pix_t tbl [16] = '{
    '{113,480,18}, '{112,480,0}, '{320,480,18}, '{321,480,0},
    '{322,480,0},  '{323,480,18}, '{740,13,18}, '{741,13,0},
    '{740,12,0},   '{500,91,0},  '{500,90,18}, '{500,412,0},
    '{500,411,0},  '{500,410,18}, '{500,491,0}, '{500,490,18}
  };

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pix(int h, int v);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 6; r++)
        if (alive[c][r] &&
            h >= 112 + 210*c + 1 && h < 112 + 210*(c+1) - 1 &&
            v >= 492 - (80*(r+1) - 1) && v < 492 - (80*r + 1))
          return 18;
    return 0;
  endfunction

  function automatic bit model_empty();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 6; r++)
        if (alive[c][r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_fill();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 6; r++) alive[c][r] = 1'b1;
  endtask

  task automatic chk_pix(int h, int v);
    hpos = 11'(h); vpos = 11'(v);
    tick;
    chk($sformatf("couleur(%0d,%0d)", h, v), 32'(couleur), 32'(model_pix(h, v)));
  endtask

  // Waits (bounded) for the ack and checks it against the model's expectation.
  task automatic wait_ack(int c, int r);
    bit got, ev;
    ev = (c < 3 && r < 6) ? alive[c][r] : 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (hit_ack) begin got = 1'b1; break; end
    end
    chk("ack_seen", 32'(got), 1);
    if (got) chk($sformatf("hit_valid(%0d,%0d)", c, r), 32'(hit_valid), 32'(ev));
    hit_req = 1'b0;
    if (ev) begin
      alive[c][r] = 1'b0;
      if (m_score < 255) m_score++;
    end
    tick;
    chk("score", 32'(score), 32'(m_score));
    chk("wall_empty", 32'(wall_empty), 32'(model_empty()));
    vpos = 11'd200;
  endtask

  task automatic do_hit(int c, int r);
    int a0;
    hpos = 11'd0; vpos = 11'd200;
    hit_col = c[1:0]; hit_row = r[2:0]; hit_req = 1'b1;
    a0 = ack_cnt;
    repeat (4) tick;
    chk("no_ack_active", 32'(ack_cnt - a0), 0);
    vpos = 11'd492;
    wait_ack(c, r);
    chk("one_ack", 32'(ack_cnt - a0), 1);
  endtask

  task automatic do_refill();
    int a0;
    a0 = ack_cnt;
    vpos = 11'd200; new_level = 1'b1;
    tick;
    new_level = 1'b0;
    repeat (3) tick;
    chk("wall_empty_pre_refill", 32'(wall_empty), 32'(model_empty()));
    vpos = 11'd492;
    tick; tick;
    model_fill();
    chk("wall_empty_refill", 32'(wall_empty), 0);
    chk("score_refill", 32'(score), 32'(m_score));
    chk("no_ack_refill", 32'(ack_cnt - a0), 0);
    vpos = 11'd200;
  endtask

  initial begin
    int a0;
    model_fill();
    #2;
    chk("rst_couleur", 32'(couleur), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_ack", 32'(hit_ack), 0);
    chk("rst_valid", 32'(hit_valid), 0);
    chk("rst_empty", 32'(wall_empty), 0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;

    foreach (tbl[i]) begin
      hpos = 11'(tbl[i].h); vpos = 11'(tbl[i].v);
      tick;
      chk($sformatf("tbl[%0d]", i), 32'(couleur), 32'(tbl[i].c));
    end

    // Single hit, repeat hit, out-of-range hits
    do_hit(1, 0);
    hpos = 11'd400; vpos = 11'd450; tick;
    chk("dead_pixel", 32'(couleur), 0);
    do_hit(1, 0);
    do_hit(3, 2);
    do_hit(0, 6);
    chk("score_after_misses", 32'(score), 1);
    for (int i = 0; i < 6; i++) chk_pix($urandom_range(100, 760), $urandom_range(0, 500));

    // Clear the whole wall, then refill
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 6; r++) do_hit(c, r);
    chk("empty_all", 32'(wall_empty), 1);
    chk("score_18", 32'(score), 18);
    do_refill();
    chk("score_18_after_refill", 32'(score), 18);
    chk_pix(113, 480);
    chk_pix(400, 450);

    // Refill and hit in the same cycle: refill wins, hit is taken afterwards
    do_hit(2, 3);
    a0 = ack_cnt;
    vpos = 11'd200; hit_col = 2'd2; hit_row = 3'd3;
    hit_req = 1'b1; new_level = 1'b1;
    tick;
    new_level = 1'b0;
    repeat (3) tick;
    chk("no_ack_simul", 32'(ack_cnt - a0), 0);
    vpos = 11'd492;
    model_fill();
    wait_ack(2, 3);
    chk("score_simul", 32'(score), 20);

    // Randomized hits and refills
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) do_refill();
      else do_hit($urandom_range(0, 3), $urandom_range(0, 7));
      chk_pix($urandom_range(100, 760), $urandom_range(0, 500));
    end

    // Reset while a hit waits for blanking
    vpos = 11'd200; hit_col = 2'd0; hit_row = 3'd0; hit_req = 1'b1;
    tick;
    hit_req = 1'b0;
    a0 = ack_cnt;
    rst_n = 1'b0;
    #2;
    chk("rst_mid_score", 32'(score), 0);
    chk("rst_mid_ack", 32'(hit_ack), 0);
    tick;
    rst_n = 1'b1;
    vpos = 11'd492;
    repeat (5) tick;
    chk("rst_mid_no_ack", 32'(ack_cnt - a0), 0);
    chk("rst_mid_empty", 32'(wall_empty), 0);
    model_fill();
    m_score = 0;
    chk_pix(113, 480);
    chk_pix(400, 450);

    // Score saturation
    for (int k = 0; k < 15; k++) begin
      do_refill();
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 6; r++) do_hit(c, r);
    end
    chk("score_sat", 32'(score), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mur_briques.md
MUR_BRIQUES -- requirements
Module: mur_briques

Interface
REQ-001 Param NB_COL, 3, number of brick columns.
REQ-002 Param NB_ROW, 6, number of brick rows.
REQ-003 Param LARGEUR_BRIQUE, 210, brick pitch in pixels, horizontal.
REQ-004 Param HAUTEUR_BRIQUE, 80, brick pitch in lines, vertical.
REQ-005 Param INTERVALLE_BRIQUE, 1, gap trimmed from each brick edge.
REQ-006 Param H_DEBUT, 112, first displayed hpos (pulse width 96 + front porch 16).
REQ-007 Param V_BAS, 492, first line after the display region (2 + 10 + 480).
REQ-008 Param COULEUR_BRIQUE, 18, colour code for a live brick.
REQ-009 Param BLANC, 0, colour code for background.
REQ-010 clk  in  1  single system clock, rising edge.
REQ-011 rst_n  in  1  reset: asynchronous assert, active-low.
REQ-012 hpos  in  11  current horizontal pixel counter.
REQ-013 vpos  in  11  current vertical line counter.
REQ-014 hit_req  in  1  collision request from ball logic; held high until hit_ack.
REQ-015 hit_col  in  2  column of the brick hit; sampled when the request is accepted.
REQ-016 hit_row  in  3  row of the brick hit (0 = bottom); sampled when the request is accepted.
REQ-017 new_level  in  1  single-cycle pulse that requests a wall refill.
REQ-018 hit_ack  out  1  one-cycle completion pulse for a hit request.
REQ-019 hit_valid  out  1  qualifies hit_ack: 1 = the brick was alive and has been removed.
REQ-020 couleur  out  5  pixel colour for the current hpos/vpos.
REQ-021 score  out  8  count of bricks destroyed.
REQ-022 wall_empty  out  1  high when no brick is alive.

Function
REQ-023 The block SHALL hold an alive bitmap of NB_COL*NB_ROW bits, one bit per brick, indexed by (col,row).
REQ-024 Brick (c,r) SHALL cover hpos in [H_DEBUT+LARGEUR_BRIQUE*c+INTERVALLE_BRIQUE, H_DEBUT+LARGEUR_BRIQUE*(c+1)-INTERVALLE_BRIQUE) and vpos in [V_BAS-(HAUTEUR_BRIQUE*(r+1)-INTERVALLE_BRIQUE), V_BAS-(HAUTEUR_BRIQUE*r+INTERVALLE_BRIQUE)).
REQ-025 couleur SHALL be registered with 1-cycle latency: COULEUR_BRIQUE if the pixel lies inside an alive brick, else BLANC.
REQ-026 Blanking SHALL be defined as vpos < V_BAS-480 or vpos >= V_BAS; the bitmap SHALL change only during blanking.
REQ-027 FSM states: IDLE, ATTENTE (hit captured), APPLIQUE, RECHARGE (refill pending).
REQ-028 IDLE with hit_req=1 and new_level=0: capture hit_col/hit_row, go to ATTENTE.
REQ-029 IDLE with new_level=1: go to RECHARGE; if hit_req is high in the same cycle, the request SHALL NOT be accepted and SHALL be taken in IDLE afterwards.
REQ-030 ATTENTE: stay until blanking, then go to APPLIQUE.
REQ-031 APPLIQUE, one cycle: if the captured coordinates are in range and the bit is 1, clear the bit and assert hit_ack=1 with hit_valid=1; otherwise assert hit_ack=1 with hit_valid=0 and leave the bitmap unchanged; then go to IDLE.
REQ-032 Out-of-range coordinates SHALL be col >= NB_COL or row >= NB_ROW.
REQ-033 RECHARGE: wait for blanking, set all bitmap bits to 1 in one cycle, then go to IDLE; score SHALL be unchanged and hit_ack SHALL NOT be asserted.
REQ-034 hit_req and new_level SHALL be ignored outside IDLE; a new_level pulse outside IDLE is lost.
REQ-035 hit_valid SHALL be 0 whenever hit_ack is 0.
REQ-036 score SHALL increment by 1 on each hit_valid=1 and saturate at 255.
REQ-037 wall_empty SHALL be registered from the bitmap and SHALL update 1 cycle after the bitmap changes.
REQ-038 Ball logic SHALL deassert hit_req in the cycle after hit_ack; a still-high hit_req in IDLE is treated as a new request.

Reset
REQ-039 On rst_n=0: FSM=IDLE, bitmap all 1, couleur=0, score=0, hit_ack=0, hit_valid=0, wall_empty=0.
REQ-040 Reset mid-operation SHALL abort any pending hit or refill with no ack.

Verification
REQ-041 Reset released, hpos=113, vpos=480 -> couleur=18 one cycle later; hpos=112 -> couleur=0 (gap pixel).
REQ-042 hit_req (col 1, row 0) at vpos=200 -> no ack before vpos=492; at blanking, one hit_ack with hit_valid=1, score=1, and pixel (hpos=400, vpos=450) reads 0 in the next frame.
REQ-043 Repeat hit on (1,0) -> hit_ack with hit_valid=0, score stays 1; hit on (3,2) or (0,6) -> hit_valid=0, bitmap unchanged.
REQ-044 Hit all 18 bricks -> wall_empty=1, score=18; new_level pulse -> after next blanking bitmap all 1, wall_empty=0, score=18.
REQ-045 new_level and hit_req in the same IDLE cycle -> refill completes first, then the hit is acked with hit_valid=1.
REQ-046 rst_n low while in ATTENTE -> no hit_ack, score=0, bitmap all 1.
